// File: rtl/hex_display_ctrl.sv
// N-digit hex 7-segment controller: loadable up/down counter with prescaled tick,
// leading-zero blanking and whole-display blink, registered active-low segments.
module hex_display_ctrl #(
   parameter int NUM_DIGITS = 6,
   parameter int TICK_DIV   = 50000000,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                      Clock,
   input  logic                      Resetn,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   din,
   input  logic                      count_en,
   input  logic                      count_dn,
   input  logic                      blank_lz,
   input  logic                      blink_en,
   output logic [4*NUM_DIGITS-1:0]   value,
   output logic                      tick,
   output logic [7*NUM_DIGITS-1:0]   HEX
);

   localparam int VW  = 4*NUM_DIGITS;
   localparam int HW  = 7*NUM_DIGITS;
   localparam int TCW = $clog2(TICK_DIV);
   localparam int BCW = $clog2(BLINK_DIV);
   localparam logic [TCW-1:0] TICK_LAST  = TCW'(TICK_DIV-1);
   localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV-1);

   logic [TCW-1:0] presc_q, presc_d;
   logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
   logic           blink_ph_q, blink_ph_d;
   logic           tick_q, tick_d;
   logic [VW-1:0]  value_q, value_d;
   logic [HW-1:0]  hex_q, hex_d;

   function automatic logic [6:0] seg7(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Prescaler only runs while counting is enabled and no load is pending.
   always_comb begin
      presc_d = '0;
      tick_d  = 1'b0;
      if (count_en && !load) begin
         if (presc_q == TICK_LAST) begin
            tick_d = 1'b1;
         end else begin
            presc_d = presc_q + TCW'(1);
         end
      end
   end

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = din;
      end else if (tick_d) begin
         value_d = count_dn ? value_q - VW'(1) : value_q + VW'(1);
      end
   end

   always_comb begin
      blink_cnt_d = blink_cnt_q + BCW'(1);
      blink_ph_d  = blink_ph_q;
      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         blink_ph_d  = ~blink_ph_q;
      end
   end

   // Walk from the top digit down; a digit is a leading zero while all above are zero.
   always_comb begin
      logic zero_above;
      hex_d      = '1;
      zero_above = 1'b1;
      for (int i = NUM_DIGITS-1; i >= 0; i--) begin
         zero_above = zero_above & (value_q[4*i +: 4] == 4'h0);
         if (blink_en && blink_ph_q) begin
            hex_d[7*i +: 7] = 7'h7F;
         end else if (blank_lz && i != 0 && zero_above) begin
            hex_d[7*i +: 7] = 7'h7F;
         end else begin
            hex_d[7*i +: 7] = seg7(value_q[4*i +: 4]);
         end
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         presc_q     <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b0;
         tick_q      <= 1'b0;
         value_q     <= '0;
         hex_q       <= '1;
      end else begin
         presc_q     <= presc_d;
         blink_cnt_q <= blink_cnt_d;
         blink_ph_q  <= blink_ph_d;
         tick_q      <= tick_d;
         value_q     <= value_d;
         hex_q       <= hex_d;
      end
   end

   assign value = value_q;
   assign tick  = tick_q;
   assign HEX   = hex_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: vector table, corner sequences and a
// cycle-level reference model driven by random stimulus.
module tb_hex_display_ctrl;

   localparam int ND = 2;
   localparam int TD = 4;
   localparam int BD = 8;
   localparam int W  = 4*ND;
   localparam int HW = 7*ND;

   logic          Clock = 1'b0;
   logic          Resetn = 1'b0;
   logic          load = 1'b0;
   logic [W-1:0]  din = '0;
   logic          count_en = 1'b0;
   logic          count_dn = 1'b0;
   logic          blank_lz = 1'b0;
   logic          blink_en = 1'b0;
   logic [W-1:0]  value;
   logic          tick;
   logic [HW-1:0] HEX;

   always #5 Clock = ~Clock;

   hex_display_ctrl #(
      .NUM_DIGITS(ND),
      .TICK_DIV  (TD),
      .BLINK_DIV (BD)
   ) dut (
      .Clock   (Clock),
      .Resetn  (Resetn),
      .load    (load),
      .din     (din),
      .count_en(count_en),
      .count_dn(count_dn),
      .blank_lz(blank_lz),
      .blink_en(blink_en),
      .value   (value),
      .tick    (tick),
      .HEX     (HEX)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference state: edges since reset and length of the current counting run.
   int            m_edges;
   int            m_run;
   logic [W-1:0]  m_value;
   logic          m_tick;
   logic [HW-1:0] m_hex;

   typedef struct {
      logic [7:0]    din;
      logic          blz;
      logic [HW-1:0] hex;
   } vec_t;

   vec_t vecs [8];

   function automatic logic [HW-1:0] disp(input logic [W-1:0] v,
                                          input logic blz, input logic blk,
                                          input logic ph);
      logic [HW-1:0] r;
      r = '1;
      for (int i = 0; i < ND; i++) begin
         if (blk && ph)
            r[7*i +: 7] = 7'h7F;
         else if (blz && i >= 1 && (v >> (4*i)) == 0)
            r[7*i +: 7] = 7'h7F;
         else
            r[7*i +: 7] = seg_tab[v[4*i +: 4]];
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_edges = 0;
      m_run   = 0;
      m_value = '0;
      m_tick  = 1'b0;
      m_hex   = '1;
   endtask

   task automatic step();
      logic q;
      logic ph;
      @(posedge Clock);
      ph    = ((m_edges / BD) % 2) == 1;
      m_hex = disp(m_value, blank_lz, blink_en, ph);
      q     = count_en && !load;
      m_run = q ? m_run + 1 : 0;
      m_tick = q && (m_run % TD == 0);
      if (load)
         m_value = din;
      else if (m_tick)
         m_value = count_dn ? m_value - 1'b1 : m_value + 1'b1;
      m_edges++;
      @(negedge Clock);
      chk("value", 32'(value), 32'(m_value));
      chk("tick", 32'(tick), 32'(m_tick));
      chk("hex", 32'(HEX), 32'(m_hex));
   endtask

   task automatic do_reset();
      #2 Resetn = 1'b0;
      #1;
      chk("rst_value", 32'(value), 32'h0);
      chk("rst_tick", 32'(tick), 32'h0);
      chk("rst_hex", 32'(HEX), 32'h3FFF);
      @(negedge Clock);
      Resetn = 1'b1;
      model_reset();
   endtask

   task automatic load_val(input logic [7:0] d);
      load = 1'b1;
      din  = d;
      step();
      load = 1'b0;
   endtask

   initial begin
      int changes;
      logic [HW-1:0] prev;
      bit found;

      vecs = '{
         '{8'h3A, 1'b0, {7'h30, 7'h08}},
         '{8'h07, 1'b1, {7'h7F, 7'h78}},
         '{8'h00, 1'b1, {7'h7F, 7'h40}},
         '{8'h70, 1'b1, {7'h78, 7'h40}},
         '{8'h00, 1'b0, {7'h40, 7'h40}},
         '{8'h12, 1'b0, {7'h79, 7'h24}},
         '{8'hF0, 1'b1, {7'h0E, 7'h40}},
         '{8'h0B, 1'b1, {7'h7F, 7'h03}}
      };

      model_reset();
      @(negedge Clock);
      Resetn = 1'b1;

      // Run a bit, then reset mid-operation.
      load_val(8'h9C);
      count_en = 1'b1;
      repeat (6) step();
      do_reset();
      count_en = 1'b0;

      // Full decode sweep.
      for (int v = 0; v < 256; v++) begin
         load_val(8'(v));
         step();
         chk("decode", 32'(HEX),
             32'({seg_tab[v / 16], seg_tab[v % 16]}));
      end

      foreach (vecs[k]) begin
         blank_lz = vecs[k].blz;
         load_val(vecs[k].din);
         step();
         chk("vec_hex", 32'(HEX), 32'(vecs[k].hex));
      end
      blank_lz = 1'b0;

      // Count up through wrap.
      load_val(8'hFE);
      count_en = 1'b1;
      count_dn = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         chk("up_tick", 32'(tick), 32'(k % 4 == 0));
         if (k == 4) chk("up_ff", 32'(value), 32'hFF);
         if (k == 8) chk("up_00", 32'(value), 32'h00);
         if (k == 12) chk("up_01", 32'(value), 32'h01);
      end

      // Count down through wrap, then flip direction between ticks.
      load_val(8'h01);
      count_dn = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k == 4) chk("dn_00", 32'(value), 32'h00);
         if (k == 8) chk("dn_ff", 32'(value), 32'hFF);
         if (k == 10) count_dn = 1'b0;
         if (k == 11) chk("dir_hold", 32'(value), 32'hFF);
         if (k == 12) begin
            chk("dir_tick", 32'(tick), 32'h1);
            chk("dir_00", 32'(value), 32'h00);
         end
      end

      // Load collides with a due tick.
      load_val(8'h00);
      repeat (3) step();
      load_val(8'h55);
      chk("coll_val", 32'(value), 32'h55);
      chk("coll_tick", 32'(tick), 32'h0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("coll_tick_n", 32'(tick), 32'(k == 4));
      end
      chk("coll_inc", 32'(value), 32'h56);
      count_en = 1'b0;

      // Blink: toggles every BD edges; turning it off shows digits next edge.
      blink_en = 1'b1;
      load_val(8'h12);
      step();
      prev = HEX;
      changes = 0;
      for (int k = 0; k < 32; k++) begin
         step();
         if (HEX != prev) changes++;
         prev = HEX;
      end
      chk("blink_toggles", 32'(changes), 32'd4);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         if (HEX == 14'h3FFF) found = 1'b1;
      end
      chk("blink_off_seen", 32'(found), 32'h1);
      blink_en = 1'b0;
      step();
      chk("blink_resume", 32'(HEX), 32'({7'h79, 7'h24}));

      // Randomized run against the reference model.
      for (int k = 0; k < 600; k++) begin
         load     = ($urandom_range(0, 9) == 0);
         din      = 8'($urandom_range(0, 255));
         count_en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 15) == 0) count_dn = ~count_dn;
         if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 29) == 0) blink_en = ~blink_en;
         if (k == 300) do_reset();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
